// File: rtl/seq_sort_div.sv
// rtl/seq_sort_div.sv - descending odd-even transposition sorter with quotient/alt-sum/remainder/range back end
module seq_sort_div #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           div_zero
);

  localparam int CW = 5;
  localparam int AW = W + $clog2(N);

  typedef enum logic [1:0] {IDLE, SORT, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       mode_q;
  logic [W-1:0]     ops      [N];
  logic [W-1:0]     pass_out [N];
  logic [2*W-1:0]   rem_q, rem_nxt, dsh;
  logic [W-1:0]     quo_q, quo_nxt;
  logic [AW-1:0]    alt_sum;
  logic [W-1:0]     result;
  logic             is_div, sort_last, calc_last;

  assign is_div    = ~mode_q[0];
  assign sort_last = (cnt == CW'(N - 1));
  assign calc_last = !is_div || (cnt == CW'(W - 1));

  // One transposition pass; pass parity follows the pass counter.
  always_comb begin
    for (int i = 0; i < N; i++) pass_out[i] = ops[i];
    for (int i = 0; i < N - 1; i++) begin
      if ((i[0] == cnt[0]) && (ops[i] < ops[i+1])) begin
        pass_out[i]   = ops[i+1];
        pass_out[i+1] = ops[i];
      end
    end
  end

  // Restoring divider step: a zero divisor naturally yields all-ones and rem = s0.
  always_comb begin
    dsh     = {{W{1'b0}}, ops[N-1]} << (CW'(W - 1) - cnt);
    rem_nxt = rem_q;
    quo_nxt = quo_q;
    if (rem_q >= dsh) begin
      rem_nxt = rem_q - dsh;
      quo_nxt = quo_q | (W'(1) << (CW'(W - 1) - cnt));
    end
  end

  // Pairwise differences of a descending list are non-negative, so no sign handling.
  always_comb begin
    alt_sum = '0;
    for (int i = 0; i < N; i += 2) alt_sum = alt_sum + (AW'(ops[i]) - AW'(ops[i+1]));
  end

  always_comb begin
    result = '0;
    case (mode_q)
      2'd0: result = quo_nxt;
      2'd1: result = W'(alt_sum);
      2'd2: result = W'(rem_nxt);
      2'd3: result = ops[0] - ops[N-1];
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = SORT;
      end
      SORT: if (sort_last) state_nxt = CALC;
      CALC: if (calc_last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mode_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      div_zero  <= 1'b0;
      for (int i = 0; i < N; i++) ops[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) ops[i] <= in_data[i*W +: W];
            mode_q <= mode;
            cnt    <= '0;
          end
        end
        SORT: begin
          for (int i = 0; i < N; i++) ops[i] <= pass_out[i];
          if (sort_last) begin
            cnt   <= '0;
            rem_q <= {{W{1'b0}}, pass_out[0]};
            quo_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + CW'(1);
          if (calc_last) begin
            out_data  <= result;
            div_zero  <= is_div && (ops[N-1] == '0);
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
